// File: rtl/pwm_deadtime_if.sv
// Gate-drive channel bundle between the PWM dead-time stage and its host.
// master: drives controls, reads gates/fault. slave: the dead-time stage.
interface pwm_deadtime_if #(
  parameter int DW = 16
);
  logic          en;
  logic          pwm_in;
  logic [DW-1:0] dt_rise;
  logic [DW-1:0] dt_fall;
  logic          fault_in;
  logic          fault_clr;
  logic          out_h;
  logic          out_l;
  logic          fault_sts;

  modport master (
    output en, pwm_in, dt_rise, dt_fall,
    output fault_in, fault_clr,
    input  out_h, out_l, fault_sts
  );

  modport slave (
    input  en, pwm_in, dt_rise, dt_fall,
    input  fault_in, fault_clr,
    output out_h, out_l, fault_sts
  );
endinterface

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with programmable dead time and fault latch.
// Ports: clk, arst_n (async, active-low), bus (slave: controls in, gates out).
module pwm_deadtime #(
  parameter int DW    = 16,
  parameter bit POL_H = 1'b1,
  parameter bit POL_L = 1'b1
) (
  input  logic           clk,
  input  logic           arst_n,
  pwm_deadtime_if.slave  bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DT_LH = 3'd1;
  localparam logic [2:0] H_ON  = 3'd2;
  localparam logic [2:0] DT_HL = 3'd3;
  localparam logic [2:0] L_ON  = 3'd4;

  logic [2:0]    state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic          pwm_q;
  logic          fault_q, fault_n;
  logic          fault;
  logic          rise_z, fall_z, cnt_z;

  assign fault  = bus.fault_in | fault_q;
  assign rise_z = (bus.dt_rise == '0);
  assign fall_z = (bus.dt_fall == '0);
  assign cnt_z  = (cnt == '0);

  // fault_in wins over a clear pulse in the same cycle
  always_comb begin
    fault_n = fault_q;
    if (bus.fault_in)
      fault_n = 1'b1;
    else if (bus.fault_clr)
      fault_n = 1'b0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (fault || !bus.en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // start-up loads the full value: dt+1 off cycles
          if (pwm_q) begin
            if (rise_z) begin
              state_n = H_ON;
            end else begin
              state_n = DT_LH;
              cnt_n   = bus.dt_rise;
            end
          end else begin
            if (fall_z) begin
              state_n = L_ON;
            end else begin
              state_n = DT_HL;
              cnt_n   = bus.dt_fall;
            end
          end
        end
        H_ON: begin
          if (!pwm_q) begin
            if (fall_z) begin
              state_n = L_ON;
            end else begin
              state_n = DT_HL;
              cnt_n   = bus.dt_fall - DW'(1);
            end
          end
        end
        L_ON: begin
          if (pwm_q) begin
            if (rise_z) begin
              state_n = H_ON;
            end else begin
              state_n = DT_LH;
              cnt_n   = bus.dt_rise - DW'(1);
            end
          end
        end
        DT_LH: begin
          // L was already off and H never turned on: safe to return
          if (!pwm_q) begin
            state_n = L_ON;
            cnt_n   = '0;
          end else if (cnt_z) begin
            state_n = H_ON;
          end else begin
            cnt_n = cnt - DW'(1);
          end
        end
        DT_HL: begin
          if (pwm_q) begin
            state_n = H_ON;
            cnt_n   = '0;
          end else if (cnt_z) begin
            state_n = L_ON;
          end else begin
            cnt_n = cnt - DW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      pwm_q         <= 1'b0;
      fault_q       <= 1'b0;
      bus.out_h     <= !POL_H;
      bus.out_l     <= !POL_L;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pwm_q         <= bus.pwm_in;
      fault_q       <= fault_n;
      bus.out_h     <= (state_n == H_ON) ^ !POL_H;
      bus.out_l     <= (state_n == L_ON) ^ !POL_L;
    end
  end

  assign bus.fault_sts = fault_q;

endmodule
